// File: rtl/hazard_stage_tracker_pkg.sv
// Shared hazard definitions: Tnew timing classes, forwarding select codes, default widths.
// Also imported by the stall-control unit so both sides agree on ALU_T/DM_T encoding.
package hazard_stage_tracker_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int T_W_DEF    = 2;

  localparam logic [1:0] NONE_T = 2'd0;
  localparam logic [1:0] ALU_T  = 2'd1;
  localparam logic [1:0] DM_T   = 2'd2;
  localparam logic [1:0] PC_T   = 2'd3;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  // A value becomes available one stage earlier than its class would suggest
  // when it is a link address (PC_T) or an ALU result (ALU_T).
  function automatic logic [2:0] stage_ready(input logic [1:0] e_t,
                                             input logic [1:0] m_t,
                                             input logic [1:0] w_t);
    logic [2:0] r;
    r[0] = (e_t == PC_T);
    r[1] = (m_t == PC_T) || (m_t == ALU_T);
    r[2] = (w_t != NONE_T);
    return r;
  endfunction

endpackage

// File: rtl/hazard_stage_tracker_if.sv
// Hazard interface between decode/stall control (master) and the stage tracker (slave).
// Optional stall statistics ports exist only when HAZ_STALL_CNT_EN is defined.
interface hazard_stage_tracker_if
  import hazard_stage_tracker_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int T_W    = T_W_DEF
);

  logic              stall;
  logic [REG_AW-1:0] d_rs;
  logic [REG_AW-1:0] d_rt;
  logic [REG_AW-1:0] d_a3;
  logic [T_W-1:0]    d_tnew;

  logic [T_W-1:0]    Tnew_E;
  logic [T_W-1:0]    Tnew_M;
  logic [T_W-1:0]    Tnew_W;
  logic [REG_AW-1:0] A3_E;
  logic [REG_AW-1:0] A3_M;
  logic [REG_AW-1:0] A3_W;

  logic [1:0]        fwd_rs_d;
  logic [1:0]        fwd_rt_d;
  logic [1:0]        fwd_rs_e;
  logic [1:0]        fwd_rt_e;
  logic              fwd_rt_m;

`ifdef HAZ_STALL_CNT_EN
  logic [31:0]       stall_cnt;
  logic              bubble_in_e;

  modport master (
    output stall, d_rs, d_rt, d_a3, d_tnew,
    input  Tnew_E, Tnew_M, Tnew_W, A3_E, A3_M, A3_W,
    input  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m,
    input  stall_cnt, bubble_in_e
  );

  modport slave (
    input  stall, d_rs, d_rt, d_a3, d_tnew,
    output Tnew_E, Tnew_M, Tnew_W, A3_E, A3_M, A3_W,
    output fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m,
    output stall_cnt, bubble_in_e
  );
`else
  modport master (
    output stall, d_rs, d_rt, d_a3, d_tnew,
    input  Tnew_E, Tnew_M, Tnew_W, A3_E, A3_M, A3_W,
    input  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m
  );

  modport slave (
    input  stall, d_rs, d_rt, d_a3, d_tnew,
    output Tnew_E, Tnew_M, Tnew_W, A3_E, A3_M, A3_W,
    output fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m
  );
`endif

endinterface

// File: rtl/hazard_stage_tracker_fwd_select.sv
// Priority forwarding select for one source register over three stages (index 0 nearest).
// Purely combinational; a matching but non-ready nearer stage blocks all farther ones.
module hazard_stage_tracker_fwd_select
  import hazard_stage_tracker_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
)(
  input  logic [REG_AW-1:0]      src_i,
  input  logic [2:0][REG_AW-1:0] a3_i,
  input  logic [2:0]             rdy_i,
  output logic [1:0]             sel_o
);

  logic [2:0] hit;

  always_comb begin
    hit = '0;
    for (int k = 0; k < 3; k++) begin
      hit[k] = (a3_i[k] == src_i) && (src_i != '0);
    end
  end

  always_comb begin
    sel_o = FWD_RF;
    if (hit[0]) begin
      sel_o = rdy_i[0] ? FWD_E : FWD_RF;
    end else if (hit[1]) begin
      sel_o = rdy_i[1] ? FWD_M : FWD_RF;
    end else if (hit[2]) begin
      sel_o = rdy_i[2] ? FWD_W : FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_stage_tracker.sv
// Carries D-stage destination/Tnew through E/M/W and derives forwarding selects for D/E/M consumers.
// Stall inserts an E-stage bubble; HAZ_STALL_CNT_EN adds stall_cnt and bubble_in_e.
module hazard_stage_tracker
  import hazard_stage_tracker_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int T_W    = T_W_DEF
)(
  input  logic                    clk,
  input  logic                    reset,
  hazard_stage_tracker_if.slave   hz
);

  logic [REG_AW-1:0] e_rs_q, e_rs_d;
  logic [REG_AW-1:0] e_rt_q, e_rt_d;
  logic [REG_AW-1:0] e_a3_q, e_a3_d;
  logic [T_W-1:0]    e_tnew_q, e_tnew_d;
  logic [REG_AW-1:0] m_rt_q, m_rt_d;
  logic [REG_AW-1:0] m_a3_q, m_a3_d;
  logic [T_W-1:0]    m_tnew_q, m_tnew_d;
  logic [REG_AW-1:0] w_a3_q, w_a3_d;
  logic [T_W-1:0]    w_tnew_q, w_tnew_d;

  logic [2:0]        rdy;

  always_comb begin
    e_rs_d   = hz.d_rs;
    e_rt_d   = hz.d_rt;
    e_a3_d   = hz.d_a3;
    e_tnew_d = hz.d_tnew;
    // A bubble looks exactly like a nop: no sources, no destination.
    if (hz.stall) begin
      e_rs_d   = '0;
      e_rt_d   = '0;
      e_a3_d   = '0;
      e_tnew_d = T_W'(NONE_T);
    end
    m_rt_d   = e_rt_q;
    m_a3_d   = e_a3_q;
    m_tnew_d = e_tnew_q;
    w_a3_d   = m_a3_q;
    w_tnew_d = m_tnew_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_rs_q   <= '0;
      e_rt_q   <= '0;
      e_a3_q   <= '0;
      e_tnew_q <= '0;
      m_rt_q   <= '0;
      m_a3_q   <= '0;
      m_tnew_q <= '0;
      w_a3_q   <= '0;
      w_tnew_q <= '0;
    end else begin
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      e_a3_q   <= e_a3_d;
      e_tnew_q <= e_tnew_d;
      m_rt_q   <= m_rt_d;
      m_a3_q   <= m_a3_d;
      m_tnew_q <= m_tnew_d;
      w_a3_q   <= w_a3_d;
      w_tnew_q <= w_tnew_d;
    end
  end

  assign rdy = stage_ready(e_tnew_q, m_tnew_q, w_tnew_q);

  assign hz.Tnew_E = e_tnew_q;
  assign hz.Tnew_M = m_tnew_q;
  assign hz.Tnew_W = w_tnew_q;
  assign hz.A3_E   = e_a3_q;
  assign hz.A3_M   = m_a3_q;
  assign hz.A3_W   = w_a3_q;

  hazard_stage_tracker_fwd_select #(.REG_AW(REG_AW)) u_fwd_rs_d (
    .src_i (hz.d_rs),
    .a3_i  ({w_a3_q, m_a3_q, e_a3_q}),
    .rdy_i (rdy),
    .sel_o (hz.fwd_rs_d)
  );

  hazard_stage_tracker_fwd_select #(.REG_AW(REG_AW)) u_fwd_rt_d (
    .src_i (hz.d_rt),
    .a3_i  ({w_a3_q, m_a3_q, e_a3_q}),
    .rdy_i (rdy),
    .sel_o (hz.fwd_rt_d)
  );

  // E-stage consumers only look at M and W; slot 0 is tied off so it can never hit.
  hazard_stage_tracker_fwd_select #(.REG_AW(REG_AW)) u_fwd_rs_e (
    .src_i (e_rs_q),
    .a3_i  ({w_a3_q, m_a3_q, {REG_AW{1'b0}}}),
    .rdy_i ({rdy[2:1], 1'b0}),
    .sel_o (hz.fwd_rs_e)
  );

  hazard_stage_tracker_fwd_select #(.REG_AW(REG_AW)) u_fwd_rt_e (
    .src_i (e_rt_q),
    .a3_i  ({w_a3_q, m_a3_q, {REG_AW{1'b0}}}),
    .rdy_i ({rdy[2:1], 1'b0}),
    .sel_o (hz.fwd_rt_e)
  );

  assign hz.fwd_rt_m = (m_rt_q == w_a3_q) && (w_a3_q != '0) && rdy[2];

`ifdef HAZ_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        bubble_q, bubble_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + (hz.stall ? 32'd1 : 32'd0);
    bubble_d    = hz.stall;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      bubble_q    <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      bubble_q    <= bubble_d;
    end
  end

  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.bubble_in_e = bubble_q;
`endif

endmodule

// File: tb/tb_hazard_stage_tracker.sv
// Directed bench for hazard_stage_tracker: hand-computed forwarding/stage expectations.
module tb_hazard_stage_tracker;
  import hazard_stage_tracker_pkg::*;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  hazard_stage_tracker_if hz ();

  hazard_stage_tracker dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] a3,
                       input logic [1:0] tn, input logic st);
    hz.d_rs   = rs;
    hz.d_rt   = rt;
    hz.d_a3   = a3;
    hz.d_tnew = tn;
    hz.stall  = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    drive(0, 0, 0, NONE_T, 0);
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    // Random inputs while held in reset must not leak into any stage.
    for (int i = 0; i < 4; i++) begin
      drive(5'($urandom), 5'($urandom), 5'($urandom), 2'($urandom), 1'($urandom));
      tick();
    end
    drive(0, 0, 0, NONE_T, 0);
    reset = 1'b1;
    check("rst_tnew_e", 32'(hz.Tnew_E), 0);
    check("rst_tnew_m", 32'(hz.Tnew_M), 0);
    check("rst_tnew_w", 32'(hz.Tnew_W), 0);
    check("rst_a3_e", 32'(hz.A3_E), 0);
    check("rst_a3_m", 32'(hz.A3_M), 0);
    check("rst_a3_w", 32'(hz.A3_W), 0);
    check("rst_fwd_rs_d", 32'(hz.fwd_rs_d), 0);
    check("rst_fwd_rt_d", 32'(hz.fwd_rt_d), 0);
    check("rst_fwd_rs_e", 32'(hz.fwd_rs_e), 0);
    check("rst_fwd_rt_e", 32'(hz.fwd_rt_e), 0);
    check("rst_fwd_rt_m", 32'(hz.fwd_rt_m), 0);
`ifdef HAZ_STALL_CNT_EN
    check("rst_stall_cnt", hz.stall_cnt, 0);
`endif

    // ALU chain: addu $8 then a reader of $8.
    drive(0, 0, 8, ALU_T, 0);
    tick();
    check("alu_a3_e", 32'(hz.A3_E), 8);
    check("alu_tnew_e", 32'(hz.Tnew_E), 1);
    drive(8, 0, 0, NONE_T, 0);
    check("alu_fwd_rs_d_e_not_ready", 32'(hz.fwd_rs_d), 0);
    tick();
    drive(0, 0, 0, NONE_T, 0);
    check("alu_a3_m", 32'(hz.A3_M), 8);
    check("alu_fwd_rs_e_m", 32'(hz.fwd_rs_e), 2);
    flush();

    // Load-use: lw $9, consumer reads rt=$9 and stalls once.
    drive(0, 0, 9, DM_T, 0);
    tick();
    drive(0, 9, 0, NONE_T, 1);
    check("lu_fwd_rt_d_e_blocked", 32'(hz.fwd_rt_d), 0);
    tick();
    check("lu_bubble_tnew_e", 32'(hz.Tnew_E), 0);
    check("lu_bubble_a3_e", 32'(hz.A3_E), 0);
    check("lu_tnew_m", 32'(hz.Tnew_M), 2);
    check("lu_a3_m", 32'(hz.A3_M), 9);
`ifdef HAZ_STALL_CNT_EN
    check("lu_bubble_in_e", 32'(hz.bubble_in_e), 1);
`endif
    drive(0, 9, 0, NONE_T, 0);
    check("lu_fwd_rt_d_m_dm", 32'(hz.fwd_rt_d), 0);
    tick();
    check("lu_fwd_rt_d_w", 32'(hz.fwd_rt_d), 3);
    check("lu_fwd_rt_e_w", 32'(hz.fwd_rt_e), 3);
    check("lu_a3_w", 32'(hz.A3_W), 9);
    check("lu_tnew_w", 32'(hz.Tnew_W), 2);
    flush();

    // jal: link value usable straight out of E.
    drive(0, 0, 31, PC_T, 0);
    tick();
    drive(31, 0, 0, NONE_T, 0);
    check("jal_fwd_rs_d_e", 32'(hz.fwd_rs_d), 1);
    tick();
    check("jal_fwd_rs_d_m", 32'(hz.fwd_rs_d), 2);
    check("jal_fwd_rs_e_m", 32'(hz.fwd_rs_e), 2);
    tick();
    check("jal_fwd_rs_d_w", 32'(hz.fwd_rs_d), 3);
    check("jal_fwd_rs_e_w", 32'(hz.fwd_rs_e), 3);
    flush();

    // $0 destination never forwards even with a ready class.
    drive(0, 0, 0, PC_T, 0);
    tick();
    drive(0, 0, 0, NONE_T, 0);
    check("zero_a3_e", 32'(hz.A3_E), 0);
    check("zero_tnew_e", 32'(hz.Tnew_E), 3);
    check("zero_fwd_rs_d", 32'(hz.fwd_rs_d), 0);
    flush();

    // Priority: non-ready E blocks M; with both ready, E wins.
    drive(0, 0, 5, ALU_T, 0);
    tick();
    drive(0, 0, 5, DM_T, 0);
    tick();
    drive(5, 5, 0, NONE_T, 0);
    check("prio_blocked_rs", 32'(hz.fwd_rs_d), 0);
    drive(0, 0, 5, PC_T, 0);
    tick();
    tick();
    drive(5, 5, 0, NONE_T, 0);
    check("prio_e_wins_rs", 32'(hz.fwd_rs_d), 1);
    check("prio_e_wins_rt", 32'(hz.fwd_rt_d), 1);
    flush();

    // Store data: lw $4 then sw rt=$4, forwarded from W when sw reaches M.
    drive(0, 0, 4, DM_T, 0);
    tick();
    drive(0, 4, 0, NONE_T, 0);
    tick();
    drive(0, 0, 0, NONE_T, 0);
    check("st_fwd_rt_m_early", 32'(hz.fwd_rt_m), 0);
    tick();
    check("st_fwd_rt_m", 32'(hz.fwd_rt_m), 1);

    // Asynchronous reset between edges clears state immediately.
    #2 reset = 1'b0;
    #1;
    check("arst_a3_w", 32'(hz.A3_W), 0);
    check("arst_tnew_w", 32'(hz.Tnew_W), 0);
    check("arst_a3_m", 32'(hz.A3_M), 0);
    check("arst_fwd_rt_m", 32'(hz.fwd_rt_m), 0);
    tick();
    reset = 1'b1;
    drive(4, 4, 0, NONE_T, 0);
    check("arst_fwd_rs_d", 32'(hz.fwd_rs_d), 0);
    check("arst_fwd_rt_d", 32'(hz.fwd_rt_d), 0);
    tick();
    check("arst_fwd_rt_e", 32'(hz.fwd_rt_e), 0);

`ifdef HAZ_STALL_CNT_EN
    check("cnt_after_reset", hz.stall_cnt, 0);
    drive(0, 0, 0, NONE_T, 1);
    for (int i = 0; i < 3; i++) tick();
    check("cnt_three", hz.stall_cnt, 3);
    check("cnt_bubble_hi", 32'(hz.bubble_in_e), 1);
    drive(0, 0, 0, NONE_T, 0);
    tick();
    check("cnt_hold", hz.stall_cnt, 3);
    check("cnt_bubble_lo", 32'(hz.bubble_in_e), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_stage_tracker.md
Name: hazard_stage_tracker

Overview:
- Producer side of the pipeline hazard interface in the 5-stage MIPS core.
- Captures each D-stage instruction's destination register and result-timing class, then carries them through E/M/W in lock-step with the datapath pipeline registers.
- Drives Tnew_E, Tnew_M and A3 to the stall-control unit, and consumes its stall output to insert E-stage bubbles.
- Also produces the forwarding-mux selects for D, E and M operand consumers.

Parameters:
- REG_AW, 5, register-address width.
- T_W, 2, width of the Tnew class code.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all stage state.
- stall  in  1  from stall control; hold D, bubble into E.
- d_rs  in  REG_AW  rs field of D-stage instruction.
- d_rt  in  REG_AW  rt field of D-stage instruction.
- d_a3  in  REG_AW  destination reg of D instr; 0 = no write.
- d_tnew  in  T_W  class of D instr: NONE_T=0, ALU_T=1, DM_T=2, PC_T=3 (link value, known at D).
- Tnew_E / Tnew_M / Tnew_W  out  T_W  class held in E/M/W stage.
- A3_E / A3_M / A3_W  out  REG_AW  destination held in E/M/W stage.
- fwd_rs_d / fwd_rt_d  out  2  D-stage operand select: 0 RF, 1 E, 2 M, 3 W.
- fwd_rs_e / fwd_rt_e  out  2  E-stage operand select: 0 no forward, 2 M, 3 W.
- fwd_rt_m  out  1  M-stage store data from W.

Behaviour:
- Internal stage registers: E{rs,rt,a3,tnew}, M{rt,a3,tnew}, W{a3,tnew}.
- Reset (asserted low, async): all fields 0. All outputs 0, all selects 0.
- Normal edge (stall=0): E<=D inputs; M<=E; W<=M.
- Stall edge (stall=1):
  - E<=bubble (rs=rt=a3=0, tnew=NONE_T); M<=E; W<=M.
  - D inputs are held externally and re-sampled next cycle.
- A stage with a3==0 never forwards and never matches, whatever its tnew. A bubble is indistinguishable from a nop.
- Readiness of the value held in a stage:
  - E: ready iff tnew==PC_T.
  - M: ready iff tnew∈{PC_T,ALU_T}.
  - W: ready iff tnew!=NONE_T.
- Forward condition for source s from stage X: A3_X==s and s!=0 and X ready.
- D-stage selects: priority E>M>W, else 0. A matching but non-ready nearer stage blocks farther stages (select 0); stall control covers that case.
- E-stage selects use E.rs/E.rt, stages M then W; matching non-ready M blocks W.
- fwd_rt_m=1 iff M.rt==A3_W, A3_W!=0, W ready.
- Selects are purely combinational from current stage registers and d_rs/d_rt. Zero-cycle latency; Tnew/A3 outputs are registered.
- Simultaneous stall and reset: reset wins.
- Reset deasserted mid-program: pipeline restarts empty; no stale forwarding.

Optional Feature:
- Macro HAZ_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt (32 bits): count of cycles with stall=1 since reset.
  - Wraps 0xFFFFFFFF->0; cleared by reset.
  - Adds output bubble_in_e (1 bit): registered, high for the cycle following a stall edge.
- When undefined: neither port exists; no counter logic.

Decomposition:
- Shared package/header hazard_defs holds:
  - NONE_T, ALU_T, DM_T, PC_T codes.
  - FWD_RF, FWD_E, FWD_M, FWD_W select codes.
  - REG_AW/T_W defaults.
- The stall control unit must include the same header for ALU_T/DM_T.
- One natural sub-module: fwd_select. Inputs: source reg, three (a3,tnew) stage pairs and a per-stage ready mask; output: 2-bit select. Instantiated for D-rs, D-rt, E-rs, E-rt.

Test Plan:
- Reset-to-drive: hold reset=0 with random inputs, release. All outputs 0, and fwd_* 0 for d_rs=d_rt=0.
- ALU chain: addu $8 (d_a3=8, ALU_T), then next instr d_rs=8. Cycle 2: fwd_rs_d=0 (E not ready). Cycle 3: instr in E has E.rs=8 → fwd_rs_e=2.
- Load-use stall: lw $9 (DM_T) then d_rt=9 with stall=1 one cycle. After edge, Tnew_E=0, A3_E=0, Tnew_M=2, A3_M=9. Next cycle fwd_rt_d=0 (M not ready for DM); after second edge fwd_rt_d=3.
- jal link: d_a3=31, PC_T, next d_rs=31 → fwd_rs_d=1 immediately. Two cycles later fwd_rs_d=3 if $31 is still read.
- $0 and priority: $0 writes never forward (d_a3=0, any tnew). A3_E=A3_M=5, both ready, and d_rs=5 → select 1 (E wins).
- Store data and async reset: lw $4 then sw rt=$4 → fwd_rt_m=1 when sw is in M. Assert reset mid-sequence between edges → outputs 0 immediately. With HAZ_STALL_CNT_EN, 3 stall cycles → stall_cnt=3.
